online_input_serializer: RTL
============================

ONLINE_INPUT_SERIALIZER -- requirements
Module: online_input_serializer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, giving the bits per operand word and the bit-cycles per frame; legal range 2..32.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port io_in_valid  input  1  parallel operand pair offered.
REQ-005 SHALL have port io_in_ready  output  1  serializer accepts the pair this cycle.
REQ-006 SHALL have port io_in_data_0  input  BIT_WIDTH  operand for lane 0.
REQ-007 SHALL have port io_in_data_1  input  BIT_WIDTH  operand for lane 1.
REQ-008 SHALL have port io_start  output  1  one-cycle pulse marking the first (MSB) bit of a frame.
REQ-009 SHALL have port io_inputs_0  output  1  lane-0 serial bit, MSB-first.
REQ-010 SHALL have port io_inputs_1  output  1  lane-1 serial bit, MSB-first.
REQ-011 SHALL have port io_busy  output  1  high while a frame is being emitted.
REQ-012 SHALL have port io_frameDone  output  1  one-cycle pulse on the last (LSB) bit cycle.

Function
REQ-013 SHALL implement an FSM with states IDLE and SHIFT; a transfer occurs when io_in_valid && io_in_ready.
REQ-014 A transfer in cycle k SHALL place bit BIT_WIDTH-1 of each operand on its lane in cycle k+1 and bit (BIT_WIDTH-1-i) in cycle k+1+i, for i = 0..BIT_WIDTH-1.
REQ-015 io_start SHALL be 1 only in cycle k+1; io_frameDone SHALL be 1 only in cycle k+BIT_WIDTH; io_busy SHALL be 1 in cycles k+1..k+BIT_WIDTH.
REQ-016 The bit counter SHALL be $clog2(BIT_WIDTH) bits wide and count 0..BIT_WIDTH-1 with no wrap beyond the frame; SHIFT exits to IDLE after the last bit unless a next frame starts.
REQ-017 In IDLE, io_inputs_0/1, io_start, io_frameDone and io_busy SHALL be 0.
REQ-018 io_in_data_* SHALL be sampled only on a transfer; input changes at any other time SHALL have no effect.
REQ-019 io_in_valid while io_in_ready=0 SHALL be ignored, with no loss of the frame in flight; the source holds data until ready.
REQ-020 Without the prefetch feature, io_in_ready SHALL equal (state==IDLE), giving exactly one idle cycle between back-to-back frames.

Reset
REQ-021 Asserting reset SHALL immediately force state IDLE, the counter to 0, all outputs to 0 except io_in_ready, and any holding register to empty.
REQ-022 io_in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-023 A frame interrupted by reset SHALL be discarded and never resumed or replayed.

Configuration
REQ-024 Macro ONLINE_SER_PREFETCH_EN SHALL compile in a one-entry holding register for both lanes.
REQ-025 With ONLINE_SER_PREFETCH_EN, io_in_ready SHALL be !hold_full.
REQ-026 With ONLINE_SER_PREFETCH_EN, a transfer in IDLE or in the last-bit cycle with the hold empty SHALL bypass directly to the shifter.
REQ-027 With ONLINE_SER_PREFETCH_EN, a held pair SHALL start in the cycle after io_frameDone, so frames run with zero gap and io_start coincides with the new MSB.
REQ-028 Without ONLINE_SER_PREFETCH_EN, no holding register SHALL exist and REQ-020 applies.

Structure
REQ-029 Package online_ser_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the constant ONLINE_SER_DEFAULT_WIDTH = 8.
REQ-030 Sub-module online_shift_lane SHALL implement one parallel-load, MSB-out shift register; the block SHALL instantiate it twice, one per lane.

Verification
REQ-031 BIT_WIDTH=8, data_0=0xA5, data_1=0x3C transferred at cycle 0 -> io_inputs_0 = 1,0,1,0,0,1,0,1 and io_inputs_1 = 0,0,1,1,1,1,0,0 in cycles 1..8; io_start high in cycle 1 only; io_frameDone high in cycle 8 only.
REQ-032 io_in_valid held high with 0xFF/0x00 then 0x01/0x80, macro off -> second io_start at cycle 10 with one all-zero idle cycle at cycle 9; macro on -> second io_start at cycle 9 with no gap.
REQ-033 Reset asserted mid-frame during bit 4 -> all outputs 0 in the same cycle; after release io_in_ready=1 and no remaining bits appear.
REQ-034 io_in_valid=1 with data 0x55 while busy and macro off -> ignored; the current frame completes unaltered and 0x55 is accepted at the next IDLE.
REQ-035 BIT_WIDTH=2, data_0=0b10 -> io_inputs_0 = 1,0; io_start and io_frameDone fall in consecutive cycles; the counter never exceeds 1.

Source files
------------

// File: rtl/online_ser_pkg.sv
// Shared definitions for the online input serializer.
// Holds the FSM state type, the default operand width and a helper
// for sizing the bit counter.
package online_ser_pkg;

  localparam int ONLINE_SER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serState_t;

  // Counter width for a frame of 'width' bit-cycles; never narrower than 1.
  function automatic int ctrWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/online_shift_lane.sv
// One serializer lane: parallel-load, MSB-first shift register.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset, clears the register
//   load       - capture loadData (takes priority over shift)
//   shift      - move the register one bit toward the MSB, zero-filling
//   loadData   - parallel operand word
//   serialOut  - current MSB of the register
module online_shift_lane
  import online_ser_pkg::*;
#(
  parameter int BIT_WIDTH = ONLINE_SER_DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [BIT_WIDTH-1:0] loadData,
  output logic                 serialOut
);

  logic [BIT_WIDTH-1:0] shiftReg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
    end else if (load) begin
      shiftReg <= loadData;
    end else if (shift) begin
      shiftReg <= {shiftReg[BIT_WIDTH-2:0], 1'b0};
    end
  end

  assign serialOut = shiftReg[BIT_WIDTH-1];

endmodule

// File: rtl/online_input_serializer.sv
// Online input serializer: accepts a parallel operand pair on a
// valid/ready handshake and emits both operands MSB-first, one bit per
// cycle, over BIT_WIDTH cycles with start / frameDone / busy framing.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in flight; ready for a new pair, all outputs low
// SHIFT | emitting a frame; bitCnt is the index of the bit on the lanes
//
// Ports:
//   clock, reset              - clock and asynchronous active-high reset
//   io_in_valid/io_in_ready   - handshake for the parallel operand pair
//   io_in_data_0/1            - lane 0 / lane 1 operands
//   io_start                  - high on the MSB cycle of a frame
//   io_inputs_0/1             - serial lane bits, MSB-first
//   io_busy                   - high for every bit cycle of a frame
//   io_frameDone              - high on the LSB cycle of a frame
//
// Build option: define ONLINE_SER_PREFETCH_EN to add a one-entry holding
// register so a pair offered mid-frame starts right after the current
// frame with no idle cycle. Without it, ready is only high in IDLE.
module online_input_serializer
  import online_ser_pkg::*;
#(
  parameter int BIT_WIDTH = ONLINE_SER_DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [BIT_WIDTH-1:0] io_in_data_0,
  input  logic [BIT_WIDTH-1:0] io_in_data_1,
  output logic                 io_start,
  output logic                 io_inputs_0,
  output logic                 io_inputs_1,
  output logic                 io_busy,
  output logic                 io_frameDone
);

  localparam int                CNT_W    = ctrWidth(BIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH - 1);

  serState_t            state;
  serState_t            stateNext;
  logic [CNT_W-1:0]     bitCnt;
  logic [CNT_W-1:0]     bitCntNext;
  logic                 transfer;
  logic                 lastBit;
  logic                 loadShifter;
  logic                 shiftEn;
  logic [BIT_WIDTH-1:0] loadData0;
  logic [BIT_WIDTH-1:0] loadData1;
  logic                 laneBit0;
  logic                 laneBit1;

`ifdef ONLINE_SER_PREFETCH_EN
  logic                 holdFull;
  logic                 holdFullNext;
  logic                 holdCapture;
  logic [BIT_WIDTH-1:0] holdData0;
  logic [BIT_WIDTH-1:0] holdData1;
`endif

  assign lastBit = (state == SHIFT) && (bitCnt == LAST_CNT);

  // Ready is masked by reset so nothing can be accepted while it is held.
`ifdef ONLINE_SER_PREFETCH_EN
  assign io_in_ready = !holdFull && !reset;
`else
  assign io_in_ready = (state == IDLE) && !reset;
`endif

  assign transfer = io_in_valid && io_in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      bitCnt <= '0;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    loadShifter = 1'b0;
    loadData0   = io_in_data_0;
    loadData1   = io_in_data_1;
`ifdef ONLINE_SER_PREFETCH_EN
    holdFullNext = holdFull;
    holdCapture  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (transfer) begin
          stateNext   = SHIFT;
          bitCntNext  = '0;
          loadShifter = 1'b1;
        end
      end
      SHIFT: begin
        if (!lastBit) begin
          bitCntNext = bitCnt + CNT_W'(1);
`ifdef ONLINE_SER_PREFETCH_EN
          // Mid-frame pairs park in the hold until this frame finishes.
          if (transfer) begin
            holdFullNext = 1'b1;
            holdCapture  = 1'b1;
          end
`endif
        end else begin
          bitCntNext = '0;
`ifdef ONLINE_SER_PREFETCH_EN
          // Last bit: chain the held pair, else a fresh pair, else stop.
          if (holdFull) begin
            loadShifter  = 1'b1;
            loadData0    = holdData0;
            loadData1    = holdData1;
            holdFullNext = 1'b0;
          end else if (transfer) begin
            loadShifter = 1'b1;
          end else begin
            stateNext = IDLE;
          end
`else
          stateNext = IDLE;
`endif
        end
      end
      default: begin
        stateNext  = IDLE;
        bitCntNext = '0;
      end
    endcase
  end

`ifdef ONLINE_SER_PREFETCH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      holdFull  <= 1'b0;
      holdData0 <= '0;
      holdData1 <= '0;
    end else begin
      holdFull <= holdFullNext;
      if (holdCapture) begin
        holdData0 <= io_in_data_0;
        holdData1 <= io_in_data_1;
      end
    end
  end
`endif

  assign shiftEn = (state == SHIFT) && !loadShifter;

  online_shift_lane #(.BIT_WIDTH(BIT_WIDTH)) uLane0 (
    .clock     (clock),
    .reset     (reset),
    .load      (loadShifter),
    .shift     (shiftEn),
    .loadData  (loadData0),
    .serialOut (laneBit0)
  );

  online_shift_lane #(.BIT_WIDTH(BIT_WIDTH)) uLane1 (
    .clock     (clock),
    .reset     (reset),
    .load      (loadShifter),
    .shift     (shiftEn),
    .loadData  (loadData1),
    .serialOut (laneBit1)
  );

  assign io_busy      = (state == SHIFT);
  assign io_start     = io_busy && (bitCnt == '0);
  assign io_frameDone = lastBit;
  assign io_inputs_0  = io_busy && laneBit0;
  assign io_inputs_1  = io_busy && laneBit1;

endmodule
